fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-instruction PC/IF path with a prefetching fetch unit.
- Issues sequential reads to the synchronous instruction ROM and buffers returned {pc, inst} pairs in a DEPTH-entry queue.
- Presents queue entries to decode with a valid/stall handshake, and handles branch redirects by flushing wrong-path state.
- Sits between the ROM and the IF/ID pipeline register, and generates the go-to-halt sequencing for the core.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_prefetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the prefetching fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } fetch_state_t;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h00000013;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry FIFO of {pc, inst} pairs; flush beats push and pop.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - prefetching IF stage with epoch-tagged redirect; FETCH_PERF_EN adds perf counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] END_ADDR = XLEN'(1024)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic [XLEN-1:0] rom_inst,
  output logic [XLEN-1:0] rom_addr,
  output logic            rom_re,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            id_stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            halt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int              CW  = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              epoch_q;
  logic              req_valid_q;
  logic              req_epoch_q;
  logic [XLEN-1:0]   req_addr_q;
  logic              issue_epoch;

  logic [2*XLEN-1:0] head;
  logic [CW-1:0]     count;
  logic              q_empty;
  logic              q_full;

  logic              redirect_take;
  logic [XLEN-1:0]   target;
  logic              resp_ok;
  logic              resp_drop;
  logic              pop;
  logic              credit_ok;

  assign redirect_take = redirect && (state_q == RUN || state_q == DRAIN);
  assign target        = {redirect_addr[XLEN-1:2], 2'b00};
  assign resp_ok       = req_valid_q && (req_epoch_q == epoch_q) && !redirect_take;
  assign resp_drop     = req_valid_q && !resp_ok;
  assign pop           = !q_empty && !id_stall && !redirect;
  // Credits count the queue plus the one possible in-flight read, never the same-cycle pop.
  assign credit_ok     = (count + CW'(req_valid_q)) < CW'(DEPTH);

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN),
    .CW    (CW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_ok),
    .push_data ({req_addr_q, rom_inst}),
    .pop       (pop),
    .flush     (redirect_take),
    .head      (head),
    .count     (count),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    rom_re      = 1'b0;
    rom_addr    = '0;
    issue_epoch = epoch_q;
    case (state_q)
      IDLE: begin
        if (go) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (redirect_take) begin
          fetch_pc_d = target;
          if (target == END_ADDR) begin
            state_d = DRAIN;
          end else begin
            state_d     = RUN;
            rom_re      = 1'b1;
            rom_addr    = target;
            fetch_pc_d  = target + INC;
            issue_epoch = ~epoch_q;
          end
        end else if (state_q == RUN) begin
          if (fetch_pc_q == END_ADDR) begin
            state_d = DRAIN;
          end else if (credit_ok) begin
            rom_re     = 1'b1;
            rom_addr   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + INC;
          end
        end else if (!req_valid_q && count == CW'(pop)) begin
          // Last entry leaves this cycle, so halt rises on the following one.
          state_d = HALT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      epoch_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_epoch_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= rom_re;
      if (redirect_take) epoch_q <= ~epoch_q;
      if (rom_re) begin
        req_epoch_q <= issue_epoch;
        req_addr_q  <= rom_addr;
      end
    end
  end

  assign id_valid = !q_empty;
  assign id_pc    = q_empty ? '0 : head[2*XLEN-1:XLEN];
  assign id_inst  = q_empty ? '0 : head[XLEN-1:0];
  assign halt     = (state_q == HALT);

`ifdef FETCH_PERF_EN
  logic [CW-1:0] flush_cnt;
  logic [32:0]   fetched_sum;
  logic [32:0]   flushed_sum;

  always_comb begin
    flush_cnt   = (redirect_take ? count : '0) + CW'(resp_drop);
    fetched_sum = {1'b0, perf_fetched} + 33'(pop);
    flushed_sum = {1'b0, perf_flushed} + 33'(flush_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - randomized scoreboard bench for fetch_prefetch_unit.
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        go, redirect, id_stall;
  logic [31:0] redirect_addr;
  logic [31:0] rom_inst, rom_addr, id_inst, id_pc;
  logic        rom_re, id_valid, halt;
  logic        e_go, e_redirect, e_stall;
  logic [31:0] e_redirect_addr;
  logic [31:0] e_rom_inst, e_rom_addr, e_id_inst, e_id_pc;
  logic        e_rom_re, e_id_valid, e_halt;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, e_perf_fetched, e_perf_flushed;
`endif

  logic [31:0] rom_mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .go(go), .rom_inst(rom_inst), .rom_addr(rom_addr),
    .rom_re(rom_re), .redirect(redirect), .redirect_addr(redirect_addr),
    .id_stall(id_stall), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .halt(halt)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  fetch_prefetch_unit #(.DEPTH(DEPTH), .END_ADDR(32'd16)) dut_e (
    .clk(clk), .reset(reset), .go(e_go), .rom_inst(e_rom_inst), .rom_addr(e_rom_addr),
    .rom_re(e_rom_re), .redirect(e_redirect), .redirect_addr(e_redirect_addr),
    .id_stall(e_stall), .id_valid(e_id_valid), .id_inst(e_id_inst), .id_pc(e_id_pc),
    .halt(e_halt)
`ifdef FETCH_PERF_EN
    , .perf_fetched(e_perf_fetched), .perf_flushed(e_perf_flushed)
`endif
  );

  always @(posedge clk) begin
    if (rom_re)   rom_inst   <= rom_mem[rom_addr[9:2]];
    if (e_rom_re) e_rom_inst <= rom_mem[e_rom_addr[9:2]];
  end

  task automatic do_reset();
    reset = 1'b0; go = 1'b0; redirect = 1'b0; id_stall = 1'b0; redirect_addr = '0;
    e_go = 1'b0; e_redirect = 1'b0; e_stall = 1'b0; e_redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic start_go();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 1'b0; redirect = 1'b0; id_stall = 1'b0; redirect_addr = '0;
    e_go = 1'b0; e_redirect = 1'b0; e_stall = 1'b0; e_redirect_addr = '0;
    #1;
    checks++; if (rom_re !== 1'b0)   begin failures++; $display("FAIL reset_rom_re got=%b exp=0", rom_re); end
    checks++; if (rom_addr !== '0)   begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    checks++; if (id_inst !== '0)    begin failures++; $display("FAIL reset_id_inst got=%h exp=0", id_inst); end
    checks++; if (id_pc !== '0)      begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    checks++; if (halt !== 1'b0)     begin failures++; $display("FAIL reset_halt got=%b exp=0", halt); end
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rom_re !== 1'b0 || id_valid !== 1'b0) begin
      failures++; $display("FAIL idle_without_go rom_re=%b id_valid=%b exp=0,0", rom_re, id_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic exp_v;
    do_reset();
    for (int n = 0; n < 256; n++) rom_mem[n] = 32'h100 + 32'(n);
    start_go();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (rom_re !== 1'b1 || rom_addr !== 32'(4 * k)) begin
        failures++; $display("FAIL stream_issue k=%0d got=%b/%h exp=1/%h", k, rom_re, rom_addr, 32'(4 * k));
      end
      exp_v = (k >= 2);
      checks++;
      if (id_valid !== exp_v) begin
        failures++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, id_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (id_pc !== 32'(4 * (k - 2)) || id_inst !== 32'h100 + 32'(k - 2)) begin
          failures++; $display("FAIL stream_data k=%0d got=%h/%h exp=%h/%h", k, id_pc, id_inst,
                               32'(4 * (k - 2)), 32'h100 + 32'(k - 2));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int issues;
    int got;
    logic [31:0] exp_pc;
    do_reset();
    id_stall = 1'b1;
    start_go();
    issues = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rom_re) begin
        checks++;
        if (rom_addr !== 32'(4 * issues) || k != issues) begin
          failures++; $display("FAIL stall_issue k=%0d got=%h exp=%h", k, rom_addr, 32'(4 * issues));
        end
        issues++;
      end
      @(posedge clk); #1;
    end
    checks++; if (issues != DEPTH) begin failures++; $display("FAIL stall_issue_count got=%0d exp=%0d", issues, DEPTH); end
    @(negedge clk);
    checks++;
    if (rom_re !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
      failures++; $display("FAIL stall_hold got=%b/%b/%h exp=0/1/0", rom_re, id_valid, id_pc);
    end
    @(posedge clk); #1;
    id_stall = 1'b0;
    exp_pc = '0; got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (id_valid && !id_stall) begin
        checks++;
        if (id_pc !== exp_pc || id_inst !== rom_mem[exp_pc[9:2]]) begin
          failures++; $display("FAIL stall_release got=%h/%h exp=%h/%h", id_pc, id_inst, exp_pc, rom_mem[exp_pc[9:2]]);
        end
        exp_pc += 32'd4; got++;
      end
      @(posedge clk); #1;
    end
    checks++; if (got != 12) begin failures++; $display("FAIL stall_release_rate got=%0d exp=12", got); end
  endtask

  task automatic test_redirect();
    do_reset();
    id_stall = 1'b1;
    start_go();
    repeat (4) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_addr = 32'h43;
    @(negedge clk);
    checks++;
    if (rom_re !== 1'b1 || rom_addr !== 32'h40) begin
      failures++; $display("FAIL redirect_issue got=%b/%h exp=1/40", rom_re, rom_addr);
    end
    @(posedge clk); #1;
    redirect = 1'b0; id_stall = 1'b0;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush got=%b exp=0", id_valid); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_flushed !== 32'd4) begin failures++; $display("FAIL redirect_perf_flushed got=%0d exp=4", perf_flushed); end
`endif
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h40 + 32'(4 * k) || id_inst !== rom_mem[16 + k]) begin
        failures++; $display("FAIL redirect_path k=%0d got=%b/%h exp=1/%h", k, id_valid, id_pc, 32'h40 + 32'(4 * k));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_perf();
`ifdef FETCH_PERF_EN
    int pops;
    do_reset();
    @(negedge clk);
    checks++;
    if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0) begin
      failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetched, perf_flushed);
    end
    @(posedge clk); #1;
    id_stall = 1'b1;
    start_go();
    repeat (3) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_addr = 32'h80;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (perf_flushed !== 32'd3 || perf_fetched !== 32'd0) begin
      failures++; $display("FAIL perf_flush got=%0d/%0d exp=3/0", perf_flushed, perf_fetched);
    end
    @(posedge clk); #1;
    pops = 0;
    for (int k = 0; k < 30; k++) begin
      id_stall = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (id_valid && !id_stall) pops++;
      @(posedge clk); #1;
    end
    id_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (perf_fetched !== 32'(pops)) begin
      failures++; $display("FAIL perf_fetched got=%0d exp=%0d", perf_fetched, pops);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, next_fetch, target;
    int outstanding, pops, fl;
    do_reset();
    for (int n = 0; n < 256; n++) rom_mem[n] = $urandom;
    start_go();
    exp_pc = '0; next_fetch = '0; outstanding = 0; pops = 0; fl = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      id_stall      = ($urandom_range(0, 3) == 0);
      redirect      = (next_fetch >= 32'h300) || ($urandom_range(0, 15) == 0);
      target        = 32'($urandom_range(0, 63)) << 2;
      redirect_addr = target | 32'($urandom_range(0, 3));
      @(negedge clk);
      if (redirect) begin
        checks++;
        if (rom_re !== 1'b1 || rom_addr !== target) begin
          failures++; $display("FAIL rand_redirect cyc=%0d got=%b/%h exp=1/%h", cyc, rom_re, rom_addr, target);
        end
        fl += outstanding;
        outstanding = 1; next_fetch = target + 32'd4; exp_pc = target;
      end else begin
        if (rom_re) begin
          checks++;
          if (rom_addr !== next_fetch || outstanding >= DEPTH) begin
            failures++; $display("FAIL rand_issue cyc=%0d got=%h exp=%h outstanding=%0d", cyc, rom_addr, next_fetch, outstanding);
          end
          next_fetch += 32'd4; outstanding++;
        end
        if (id_valid && !id_stall) begin
          checks++;
          if (id_pc !== exp_pc || id_inst !== rom_mem[exp_pc[9:2]]) begin
            failures++; $display("FAIL rand_deliver cyc=%0d got=%h/%h exp=%h/%h", cyc, id_pc, id_inst, exp_pc, rom_mem[exp_pc[9:2]]);
          end
          exp_pc += 32'd4; outstanding--; pops++;
        end
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0; id_stall = 1'b0;
    checks++; if (pops < 150) begin failures++; $display("FAIL rand_throughput got=%0d exp>=150", pops); end
`ifdef FETCH_PERF_EN
    @(negedge clk);
    checks++;
    if (perf_flushed !== 32'(fl) || perf_fetched !== 32'(pops)) begin
      failures++; $display("FAIL rand_perf got=%0d/%0d exp=%0d/%0d", perf_flushed, perf_fetched, fl, pops);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_end_addr();
    int issues, pops, last_pop, halt_cyc, late_re;
    do_reset();
    e_go = 1'b1;
    @(posedge clk); #1;
    e_go = 1'b0;
    issues = 0; pops = 0; last_pop = -10; halt_cyc = -1; late_re = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (e_halt && halt_cyc < 0) halt_cyc = k;
      if (e_rom_re) begin
        if (halt_cyc >= 0) late_re++;
        checks++;
        if (e_rom_addr !== 32'(4 * issues)) begin
          failures++; $display("FAIL end_issue got=%h exp=%h", e_rom_addr, 32'(4 * issues));
        end
        issues++;
      end
      if (e_id_valid && !e_stall) begin
        checks++;
        if (e_id_pc !== 32'(4 * pops) || e_id_inst !== rom_mem[pops]) begin
          failures++; $display("FAIL end_deliver got=%h exp=%h", e_id_pc, 32'(4 * pops));
        end
        pops++; last_pop = k;
      end
      @(posedge clk); #1;
    end
    checks++; if (issues != 4) begin failures++; $display("FAIL end_issue_count got=%0d exp=4", issues); end
    checks++; if (pops != 4) begin failures++; $display("FAIL end_pop_count got=%0d exp=4", pops); end
    checks++; if (halt_cyc != last_pop + 1) begin failures++; $display("FAIL end_halt_timing got=%0d exp=%0d", halt_cyc, last_pop + 1); end
    checks++; if (late_re != 0) begin failures++; $display("FAIL end_re_after_halt got=%0d exp=0", late_re); end
    e_go = 1'b1; e_redirect = 1'b1; e_redirect_addr = 32'h0;
    @(negedge clk);
    checks++;
    if (e_rom_re !== 1'b0 || e_halt !== 1'b1) begin
      failures++; $display("FAIL halt_ignores_redirect got=%b/%b exp=0/1", e_rom_re, e_halt);
    end
    @(posedge clk); #1;
    e_go = 1'b0; e_redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (e_rom_re !== 1'b0 || e_halt !== 1'b1 || e_id_valid !== 1'b0) begin
      failures++; $display("FAIL halt_sticky got=%b/%b/%b exp=0/1/0", e_rom_re, e_halt, e_id_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    do_reset();
    start_go();
    repeat (5) @(posedge clk);
    #3;
    checks++; if (rom_re !== 1'b1 || id_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b/%b exp=1/1", rom_re, id_valid); end
    reset = 1'b0;
    #1;
    checks++;
    if (rom_re !== 1'b0 || rom_addr !== '0 || id_valid !== 1'b0 || id_inst !== '0 || id_pc !== '0 || halt !== 1'b0) begin
      failures++; $display("FAIL areset_outputs got=%b/%h/%b/%h/%h/%b exp=all zero", rom_re, rom_addr, id_valid, id_inst, id_pc, halt);
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rom_re !== 1'b0 || id_valid !== 1'b0) begin
        failures++; $display("FAIL areset_idle k=%0d got=%b/%b exp=0/0", k, rom_re, id_valid);
      end
      @(posedge clk); #1;
    end
    start_go();
    @(negedge clk);
    checks++;
    if (rom_re !== 1'b1 || rom_addr !== 32'h0) begin
      failures++; $display("FAIL areset_restart got=%b/%h exp=1/0", rom_re, rom_addr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_perf();
    test_random();
    test_end_addr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
